// File: rtl/bus_uart_tx.sv
// Bus-mapped 8N1 UART transmitter with TXDATA/STATUS/DIVISOR registers.
// Define BUS_UART_TX_FIFO_EN for a 4-entry queue; otherwise a single holding register.
module bus_uart_tx #(
  parameter int unsigned DEFAULT_DIVISOR = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  output logic        tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [1:0] A_TXDATA  = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_DIVISOR = 2'd2;

`ifdef BUS_UART_TX_FIFO_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  state_t      r_state, w_state_next;
  logic        r_response;
  logic [31:0] r_read_data;
  logic        r_overflow;
  logic [15:0] r_divisor;
  logic [2:0]  r_count;
  logic [15:0] r_bit_cnt;
  logic [15:0] r_div_lat;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;

  logic        w_accept;
  logic [1:0]  w_sel;
  logic        w_wr_txdata;
  logic        w_rd_status;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_bit_end;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_unused_bits = ^{option, address[31:4], address[1:0], write_data[31:16]};

  // A simultaneous read+write is a write, so only the write level is decoded.
  assign w_accept    = (read | write) & ~r_response;
  assign w_sel       = address[3:2];
  assign w_wr_txdata = w_accept & write & (w_sel == A_TXDATA);
  assign w_rd_status = w_accept & ~write & (w_sel == A_STATUS);

  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == DEPTH);
  assign w_busy  = (r_state != IDLE);
  assign w_push  = w_wr_txdata & (~w_full | w_pop);

  assign w_status = {25'd0, r_count, r_overflow, w_empty, w_full, w_busy};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    w_rdata = 32'd0;
    if (w_accept && !write) begin
      case (w_sel)
        A_STATUS:  w_rdata = w_status;
        A_DIVISOR: w_rdata = {16'd0, r_divisor};
        default:   w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_response  <= 1'b0;
      r_read_data <= 32'd0;
      r_overflow  <= 1'b0;
      r_divisor   <= 16'(DEFAULT_DIVISOR);
    end else begin
      r_response  <= w_accept;
      r_read_data <= w_rdata;
      if (w_wr_txdata && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_rd_status) begin
        r_overflow <= 1'b0;
      end
      if (w_accept && write && (w_sel == A_DIVISOR)) begin
        r_divisor <= write_data[15:0];
      end
    end
  end

  assign response  = r_response;
  assign read_data = r_read_data;

`ifdef BUS_UART_TX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
    end
  end

  // NOTE: queue storage is not reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= write_data[7:0];
  end

  assign w_head = r_mem[r_rd_ptr];
`else
  logic [7:0] r_hold;

  always_ff @(posedge clk) begin
    if (w_push) r_hold <= write_data[7:0];
  end

  assign w_head = r_hold;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 3'd0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 3'd1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign w_bit_end = (r_bit_cnt == r_div_lat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    tx           = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_next = START;
          w_pop        = 1'b1;
        end
      end
      START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_state_next = START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The divisor is captured with each popped byte, so later DIVISOR writes only affect later frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= 16'd0;
      r_div_lat <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else if (w_pop) begin
      r_bit_cnt <= 16'd0;
      r_div_lat <= r_divisor;
      r_bit_idx <= 3'd0;
      r_shift   <= w_head;
    end else if (r_state != IDLE) begin
      if (w_bit_end) begin
        r_bit_cnt <= 16'd0;
        if (r_state == DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: queue/frame-level model checked every cycle plus directed literal checks.
// Build with BUS_UART_TX_FIFO_EN defined to exercise the 4-entry queue variant.
`timescale 1ns/1ps
module tb_bus_uart_tx;

  localparam int unsigned DEF_DIV = 434;
`ifdef BUS_UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  option = 3'd2;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        response;
  logic        tx;

  bus_uart_tx #(.DEFAULT_DIVISOR(DEF_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read       (read),
    .write      (write),
    .option     (option),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .response   (response),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue of capacity CAP feeding a per-cycle list of expected tx levels.
  byte unsigned fq[$];
  bit           tx_q[$];
  byte unsigned sent_log[$];
  int           div_log[$];
  logic [15:0]  m_div;
  bit           m_ovf;
  bit           m_resp;
  bit           m_live = 1'b0;
  logic [31:0]  m_rd;

  task automatic model_reset();
    fq.delete();
    tx_q.delete();
    m_div  = 16'(DEF_DIV);
    m_ovf  = 1'b0;
    m_resp = 1'b0;
    m_rd   = 32'd0;
    m_live = 1'b1;
  endtask

  task automatic model_step();
    bit           acc;
    bit           pop;
    int           pre_cnt;
    logic [1:0]   sel;
    logic [31:0]  rd;
    byte unsigned b;
    logic [9:0]   frame;
    acc     = (read || write) && !m_resp;
    sel     = address[3:2];
    pre_cnt = fq.size();
    rd      = 32'd0;
    if (acc && !write) begin
      if (sel == 2'd1)
        rd = {25'd0, 3'(pre_cnt), m_ovf, (pre_cnt == 0), (pre_cnt == CAP), (tx_q.size() != 0)};
      else if (sel == 2'd2)
        rd = {16'd0, m_div};
    end
    if (tx_q.size() > 0) void'(tx_q.pop_front());
    pop = (tx_q.size() == 0) && (fq.size() > 0);
    if (pop) begin
      b = fq.pop_front();
      sent_log.push_back(b);
      div_log.push_back(int'(m_div));
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++)
        for (int k = 0; k <= int'(m_div); k++) tx_q.push_back(frame[i]);
    end
    if (acc && write) begin
      if (sel == 2'd0) begin
        if (pre_cnt < CAP || pop) fq.push_back(write_data[7:0]);
        else m_ovf = 1'b1;
      end else if (sel == 2'd2) begin
        m_div = write_data[15:0];
      end
    end else if (acc && sel == 2'd1) begin
      m_ovf = 1'b0;
    end
    m_resp = acc;
    m_rd   = rd;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else if (m_live) model_step();
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("tx", 32'(tx), 32'((tx_q.size() != 0) ? tx_q[0] : 1'b1));
      check("response", 32'(response), 32'(m_resp));
      check("read_data", read_data, m_rd);
    end
  end

  task automatic bus(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rdat);
    bit got;
    got  = 1'b0;
    rdat = 32'd0;
    @(negedge clk);
    read = rd; write = wr; address = addr; write_data = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (response) begin
        got  = 1'b1;
        rdat = read_data;
      end
    end
    read = 1'b0;
    write = 1'b0;
    check("bus_response_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [9:0]  fa5;
    fa5 = 10'b11_0100_1010;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bus(1, 0, 32'h4, 32'd0, r);
    check("status_after_reset", r, 32'h04);
    check("tx_idle_after_reset", 32'(tx), 32'd1);
    bus(1, 0, 32'h8, 32'd0, r);
    check("divisor_reset", r, 32'd434);
    bus(1, 0, 32'h0, 32'd0, r);
    check("txdata_reads_zero", r, 32'd0);
    bus(1, 0, 32'hC, 32'd0, r);
    check("reserved_reads_zero", r, 32'd0);
    bus(0, 1, 32'hC, 32'hFFFF_FFFF, r);
    bus(1, 0, 32'h8, 32'd0, r);
    check("reserved_write_ignored", r, 32'd434);
    bus(1, 1, 32'h8, 32'hABCD_0003, r);
    check("read_write_is_write", r, 32'd0);
    bus(1, 0, 32'h1000_0008, 32'd0, r);
    check("divisor_upper_bits_zero", r, 32'd3);

    bus(0, 1, 32'h0, 32'h0000_00A5, r);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("frame_a5_bit", 32'(tx), 32'(fa5[j / 4]));
    end
    @(negedge clk);
    check("frame_a5_idle_after", 32'(tx), 32'd1);
    bus(1, 0, 32'h4, 32'd0, r);
    check("status_after_a5", r, 32'h04);

    sent_log.delete();
    bus(0, 1, 32'h8, 32'd9, r);
    for (int b = 1; b <= 6; b++) bus(0, 1, 32'h0, 32'(b), r);
    bus(1, 0, 32'h4, 32'd0, r);
    check("overflow_set", 32'(r[3]), 32'd1);
    bus(1, 0, 32'h4, 32'd0, r);
    check("overflow_cleared", 32'(r[3]), 32'd0);
    repeat (600) @(negedge clk);
    check("burst_sent_count", 32'(sent_log.size()), 32'(CAP + 1));
    for (int i = 0; i < sent_log.size(); i++)
      check("burst_sent_byte", 32'(sent_log[i]), 32'(i + 1));

    sent_log.delete();
    div_log.delete();
    bus(0, 1, 32'h0, 32'h55, r);
    repeat (30) @(negedge clk);
    bus(1, 0, 32'h4, 32'd0, r);
    check("busy_mid_frame", 32'(r[0]), 32'd1);
    bus(0, 1, 32'h8, 32'd1, r);
    bus(0, 1, 32'h0, 32'h33, r);
    repeat (150) @(negedge clk);
    check("divchange_frames", 32'(div_log.size()), 32'd2);
    if (div_log.size() == 2) begin
      check("divchange_first_div", 32'(div_log[0]), 32'd9);
      check("divchange_second_div", 32'(div_log[1]), 32'd1);
      check("divchange_second_byte", 32'(sent_log[1]), 32'h33);
    end

    bus(0, 1, 32'h8, 32'd9, r);
    bus(0, 1, 32'h0, 32'h00, r);
    repeat (30) @(negedge clk);
    check("tx_low_in_data", 32'(tx), 32'd0);
    rst_n = 1'b0; read = 1'b1; address = 32'h4;
    @(negedge clk);
    check("tx_high_after_reset_edge", 32'(tx), 32'd1);
    check("no_response_in_reset", 32'(response), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_response_after_reset", 32'(response), 32'd0);
    end
    bus(1, 0, 32'h4, 32'd0, r);
    check("status_after_abort", r, 32'h04);
    bus(1, 0, 32'h8, 32'd0, r);
    check("divisor_after_abort", r, 32'd434);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
